// File: rtl/mdu_seq_ctrl_pkg.sv
// Shared MDU constants: op codes, sequencer state encoding and decode helpers.
// Used by mdu_seq_ctrl and its testbench.
package mdu_seq_ctrl_pkg;

    localparam logic [3:0] MDU_OP_NOP   = 4'd0;
    localparam logic [3:0] MDU_OP_DIV   = 4'd1;
    localparam logic [3:0] MDU_OP_DIVU  = 4'd2;
    localparam logic [3:0] MDU_OP_MUL   = 4'd3;
    localparam logic [3:0] MDU_OP_MULT  = 4'd4;
    localparam logic [3:0] MDU_OP_MULTU = 4'd5;
    localparam logic [3:0] MDU_OP_MFHI  = 4'd6;
    localparam logic [3:0] MDU_OP_MFLO  = 4'd7;
    localparam logic [3:0] MDU_OP_MTHI  = 4'd8;
    localparam logic [3:0] MDU_OP_MTLO  = 4'd9;

    typedef enum logic [1:0] {
        MDU_ST_IDLE  = 2'd0,
        MDU_ST_BUSY  = 2'd1,
        MDU_ST_DRAIN = 2'd2
    } mdu_state_t;

    // Codes 10-15 are reserved and behave exactly like NOP.
    function automatic logic mdu_op_valid(input logic [3:0] op);
        return (op != MDU_OP_NOP) && (op <= MDU_OP_MTLO);
    endfunction

    function automatic logic mdu_op_is_div(input logic [3:0] op);
        return (op == MDU_OP_DIV) || (op == MDU_OP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_seq_ctrl_if.sv
// EX-stage / divider / multiplier signal bundle of the MDU sequencer.
// slave = the sequencer, master = the surrounding pipeline and arithmetic units.
interface mdu_seq_ctrl_if #(
    parameter int WIDTH = 32
);
    logic [3:0]       mdu_op_i;
    logic [WIDTH-1:0] mdu_a_i;
    logic [WIDTH-1:0] mdu_b_i;
    logic             flush_i;
    logic [WIDTH-1:0] mdu_data_o;
    logic             mdu_stall_o;
    logic             div_start_o;
    logic             div_signed_o;
    logic             div_ready_i;
    logic             div_busy_i;
    logic [WIDTH-1:0] div_quotient_i;
    logic [WIDTH-1:0] div_remainder_i;
    logic             mul_signed_o;
    logic [WIDTH-1:0] mul_hi_i;
    logic [WIDTH-1:0] mul_lo_i;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;

    modport slave (
        input  mdu_op_i, mdu_a_i, mdu_b_i, flush_i,
        input  div_ready_i, div_busy_i, div_quotient_i, div_remainder_i,
        input  mul_hi_i, mul_lo_i,
        output mdu_data_o, mdu_stall_o, div_start_o, div_signed_o,
        output mul_signed_o, hi_o, lo_o
    );

    modport master (
        output mdu_op_i, mdu_a_i, mdu_b_i, flush_i,
        output div_ready_i, div_busy_i, div_quotient_i, div_remainder_i,
        output mul_hi_i, mul_lo_i,
        input  mdu_data_o, mdu_stall_o, div_start_o, div_signed_o,
        input  mul_signed_o, hi_o, lo_o
    );
endinterface

// File: rtl/mdu_hilo_regs.sv
// Architectural HI/LO register pair with independent write enables.
// Asynchronous active-high reset clears both words.
module mdu_hilo_regs #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             i_hi_we,
    input  logic [WIDTH-1:0] i_hi_d,
    input  logic             i_lo_we,
    input  logic [WIDTH-1:0] i_lo_d,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_hi <= '0;
            r_lo <= '0;
        end else begin
            if (i_hi_we) r_hi <= i_hi_d;
            if (i_lo_we) r_lo <= i_lo_d;
        end
    end

    assign o_hi = r_hi;
    assign o_lo = r_lo;

endmodule

// File: rtl/mdu_seq_ctrl.sv
// MDU sequencer: decodes EX-stage MDU ops, launches/tracks the divider, owns HI/LO, drives the EX stall.
// Define MDU_NONBLOCKING_DIV_EN to let DIV/DIVU retire at launch, stalling only later MDU ops.
module mdu_seq_ctrl
    import mdu_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    mdu_seq_ctrl_if.slave bus
);

    mdu_state_t       r_state;
    mdu_state_t       w_state_nxt;
    logic             r_done;
    logic             w_done_nxt;

    logic [3:0]       w_op;
    logic             w_flush;
    logic             w_is_div;
    logic             w_live;
    logic             w_stall;
    logic             w_start;
    logic [WIDTH-1:0] w_data;
    logic             w_hi_we;
    logic             w_lo_we;
    logic [WIDTH-1:0] w_hi_d;
    logic [WIDTH-1:0] w_lo_d;
    logic [WIDTH-1:0] w_hi;
    logic [WIDTH-1:0] w_lo;

    assign w_op     = bus.mdu_op_i;
    assign w_flush  = bus.flush_i;
    assign w_is_div = mdu_op_is_div(w_op);
    assign w_live   = mdu_op_valid(w_op) && !w_flush;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= MDU_ST_IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = r_done;
        w_stall     = 1'b0;
        w_start     = 1'b0;
        w_data      = '0;
        w_hi_we     = 1'b0;
        w_lo_we     = 1'b0;
        w_hi_d      = bus.mul_hi_i;
        w_lo_d      = bus.mul_lo_i;

        case (r_state)
            MDU_ST_IDLE: begin
                // done_r only survives the single cycle in which the finished DIV retires.
                w_done_nxt = 1'b0;
                if (w_is_div) begin
                    if (!w_flush) begin
`ifdef MDU_NONBLOCKING_DIV_EN
                        if (bus.div_busy_i) begin
                            w_stall = 1'b1;
                        end else begin
                            w_start     = 1'b1;
                            w_state_nxt = MDU_ST_BUSY;
                        end
`else
                        if (!r_done) begin
                            w_stall = 1'b1;
                            if (!bus.div_busy_i) begin
                                w_start     = 1'b1;
                                w_state_nxt = MDU_ST_BUSY;
                            end
                        end
`endif
                    end
                end else if (!w_flush) begin
                    case (w_op)
                        MDU_OP_MUL: begin
                            w_data  = bus.mul_lo_i;
                            w_hi_we = 1'b1;
                            w_lo_we = 1'b1;
                        end
                        MDU_OP_MULT, MDU_OP_MULTU: begin
                            w_hi_we = 1'b1;
                            w_lo_we = 1'b1;
                        end
                        MDU_OP_MFHI: w_data = w_hi;
                        MDU_OP_MFLO: w_data = w_lo;
                        MDU_OP_MTHI: begin
                            w_hi_we = 1'b1;
                            w_hi_d  = bus.mdu_a_i;
                        end
                        MDU_OP_MTLO: begin
                            w_lo_we = 1'b1;
                            w_lo_d  = bus.mdu_a_i;
                        end
                        default: ;
                    endcase
                end
            end

            MDU_ST_BUSY: begin
                // Any op arriving with the completion is held, so HI/LO has a single writer.
                w_stall = w_live;
                w_hi_d  = bus.div_remainder_i;
                w_lo_d  = bus.div_quotient_i;
`ifdef MDU_NONBLOCKING_DIV_EN
                if (bus.div_ready_i) begin
                    w_hi_we     = 1'b1;
                    w_lo_we     = 1'b1;
                    w_state_nxt = MDU_ST_IDLE;
                end
`else
                if (bus.div_ready_i) begin
                    if (!w_flush) begin
                        w_hi_we    = 1'b1;
                        w_lo_we    = 1'b1;
                        w_done_nxt = 1'b1;
                    end
                    w_state_nxt = MDU_ST_IDLE;
                end else if (w_flush) begin
                    w_state_nxt = MDU_ST_DRAIN;
                end
`endif
            end

            MDU_ST_DRAIN: begin
                // Killed divide: wait out the divider and discard its result.
                w_stall = w_live;
                if (bus.div_ready_i) w_state_nxt = MDU_ST_IDLE;
            end

            default: w_state_nxt = MDU_ST_IDLE;
        endcase

        if (w_flush) w_done_nxt = 1'b0;
    end

    mdu_hilo_regs #(
        .WIDTH (WIDTH)
    ) u_hilo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_hi_we (w_hi_we),
        .i_hi_d  (w_hi_d),
        .i_lo_we (w_lo_we),
        .i_lo_d  (w_lo_d),
        .o_hi    (w_hi),
        .o_lo    (w_lo)
    );

    assign bus.mdu_data_o   = w_data;
    assign bus.mdu_stall_o  = w_stall;
    assign bus.div_start_o  = w_start;
    assign bus.div_signed_o = (w_op == MDU_OP_DIV);
    assign bus.mul_signed_o = (w_op == MDU_OP_MUL) || (w_op == MDU_OP_MULT);
    assign bus.hi_o         = w_hi;
    assign bus.lo_o         = w_lo;

endmodule

// File: tb/tb_mdu_seq_ctrl.sv
// Testbench for mdu_seq_ctrl: vector table, directed divide/flush/reset sequences and random ops
// against a flag-based reference model plus a latency-programmable divider/multiplier model.
module tb_mdu_seq_ctrl;

`ifdef MDU_NONBLOCKING_DIV_EN
    localparam bit NB = 1'b1;
`else
    localparam bit NB = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mdu_seq_ctrl_if #(.WIDTH(32)) bus ();

    mdu_seq_ctrl #(.WIDTH(32)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_err    = 0;

    // reference model: architectural HI/LO plus divide bookkeeping flags
    logic [31:0] m_hi, m_lo;
    logic        m_inflight, m_keep, m_done;
    // divider model
    int          dv_cnt = 0;
    int          lat    = 4;
    logic [31:0] dv_q = '0, dv_r = '0;
    logic        ext_busy = 1'b0;
    // per-step expectations and observations
    logic        e_stall, e_start;
    logic [31:0] e_data;
    logic        o_stall, o_start;
    logic [31:0] o_data, o_hi, o_lo;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_hi = '0; m_lo = '0;
        m_inflight = 1'b0; m_keep = 1'b0; m_done = 1'b0;
    endtask

    // One EX cycle: drive at posedge+1, check at negedge, advance models at the next posedge.
    task automatic step(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic fl);
        logic signed [63:0] sa, sb;
        logic [63:0] p;
        logic rdy, bsy, isdiv, nonnop;
        logic [31:0] nhi, nlo;
        logic ninf, nkeep, ndone;
        bus.mdu_op_i = op; bus.mdu_a_i = a; bus.mdu_b_i = b; bus.flush_i = fl;
        if (op == 4'd3 || op == 4'd4) begin
            sa = {{32{a[31]}}, a}; sb = {{32{b[31]}}, b}; p = sa * sb;
        end else begin
            p = {32'b0, a} * {32'b0, b};
        end
        bus.mul_hi_i = p[63:32]; bus.mul_lo_i = p[31:0];
        rdy = (dv_cnt == 1);
        bsy = (dv_cnt > 1) || ext_busy;
        bus.div_ready_i = rdy; bus.div_busy_i = bsy;
        bus.div_quotient_i = dv_q; bus.div_remainder_i = dv_r;

        isdiv  = (op == 4'd1) || (op == 4'd2);
        nonnop = (op >= 4'd1) && (op <= 4'd9);
        e_stall = 1'b0; e_start = 1'b0; e_data = '0;
        nhi = m_hi; nlo = m_lo; ninf = m_inflight; nkeep = m_keep; ndone = m_done;
        if (m_inflight) begin
            e_stall = nonnop && !fl;
            if (rdy) begin
                ninf = 1'b0;
                if (NB || (m_keep && !fl)) begin
                    nhi = dv_r; nlo = dv_q; ndone = !NB;
                end
            end
            if (!NB && fl) nkeep = 1'b0;
        end else begin
            ndone = 1'b0;
            if (!fl) begin
                if (isdiv) begin
                    if (!NB && m_done) begin
                        e_stall = 1'b0;
                    end else if (bsy) begin
                        e_stall = 1'b1;
                    end else begin
                        e_start = 1'b1; e_stall = !NB; ninf = 1'b1; nkeep = 1'b1;
                    end
                end else begin
                    case (op)
                        4'd3: begin nhi = p[63:32]; nlo = p[31:0]; e_data = p[31:0]; end
                        4'd4, 4'd5: begin nhi = p[63:32]; nlo = p[31:0]; end
                        4'd6: e_data = m_hi;
                        4'd7: e_data = m_lo;
                        4'd8: nhi = a;
                        4'd9: nlo = a;
                        default: ;
                    endcase
                end
            end
        end
        if (fl) ndone = 1'b0;

        @(negedge clk);
        o_stall = bus.mdu_stall_o; o_start = bus.div_start_o; o_data = bus.mdu_data_o;
        o_hi = bus.hi_o; o_lo = bus.lo_o;
        chk("stall", {31'b0, o_stall}, {31'b0, e_stall});
        chk("div_start", {31'b0, o_start}, {31'b0, e_start});
        chk("data", o_data, e_data);
        chk("hi", o_hi, m_hi);
        chk("lo", o_lo, m_lo);
        chk("div_signed", {31'b0, bus.div_signed_o}, {31'b0, (op == 4'd1)});
        chk("mul_signed", {31'b0, bus.mul_signed_o}, {31'b0, (op == 4'd3 || op == 4'd4)});

        @(posedge clk);
        if (!rst) begin
            m_hi = nhi; m_lo = nlo; m_inflight = ninf; m_keep = nkeep; m_done = ndone;
        end
        if (o_start) begin
            dv_cnt = lat;
            if (b == 32'd0) begin
                dv_q = '1; dv_r = a;
            end else if (op == 4'd1) begin
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    dv_q = a; dv_r = '0;
                end else begin
                    dv_q = $signed(a) / $signed(b); dv_r = $signed(a) % $signed(b);
                end
            end else begin
                dv_q = a / b; dv_r = a % b;
            end
        end else if (dv_cnt > 0) begin
            dv_cnt--;
        end
        #1;
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a, b;
        logic        fl;
        logic [31:0] data, hi, lo;
    } vec_t;
    vec_t vecs[12];

    int nstall, nstart, guard;
    logic [31:0] hi_keep, lo_keep;
    logic [3:0]  r_op;
    logic [31:0] r_a, r_b;
    logic        r_fl, hold;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{op:4'd8,  a:32'h1234_5678, b:32'd0, fl:1'b0, data:32'h0,          hi:32'h1234_5678, lo:32'h0};
        vecs[1]  = '{op:4'd9,  a:32'h9ABC_DEF0, b:32'd0, fl:1'b0, data:32'h0,          hi:32'h1234_5678, lo:32'h9ABC_DEF0};
        vecs[2]  = '{op:4'd6,  a:32'd0,         b:32'd0, fl:1'b0, data:32'h1234_5678,  hi:32'h1234_5678, lo:32'h9ABC_DEF0};
        vecs[3]  = '{op:4'd7,  a:32'd0,         b:32'd0, fl:1'b0, data:32'h9ABC_DEF0,  hi:32'h1234_5678, lo:32'h9ABC_DEF0};
        vecs[4]  = '{op:4'd4,  a:32'hFFFF_FFFE, b:32'd3, fl:1'b0, data:32'h0,          hi:32'hFFFF_FFFF, lo:32'hFFFF_FFFA};
        vecs[5]  = '{op:4'd6,  a:32'd0,         b:32'd0, fl:1'b0, data:32'hFFFF_FFFF,  hi:32'hFFFF_FFFF, lo:32'hFFFF_FFFA};
        vecs[6]  = '{op:4'd7,  a:32'd0,         b:32'd0, fl:1'b0, data:32'hFFFF_FFFA,  hi:32'hFFFF_FFFF, lo:32'hFFFF_FFFA};
        vecs[7]  = '{op:4'd3,  a:32'd7,         b:32'd6, fl:1'b0, data:32'd42,         hi:32'h0,         lo:32'd42};
        vecs[8]  = '{op:4'd5,  a:32'hFFFF_FFFF, b:32'd2, fl:1'b0, data:32'h0,          hi:32'h1,         lo:32'hFFFF_FFFE};
        vecs[9]  = '{op:4'd12, a:32'h55,        b:32'd1, fl:1'b0, data:32'h0,          hi:32'h1,         lo:32'hFFFF_FFFE};
        vecs[10] = '{op:4'd8,  a:32'h77,        b:32'd0, fl:1'b1, data:32'h0,          hi:32'h1,         lo:32'hFFFF_FFFE};
        vecs[11] = '{op:4'd7,  a:32'd0,         b:32'd0, fl:1'b0, data:32'hFFFF_FFFE,  hi:32'h1,         lo:32'hFFFF_FFFE};

        bus.mdu_op_i = '0; bus.mdu_a_i = '0; bus.mdu_b_i = '0; bus.flush_i = 1'b0;
        bus.div_ready_i = 1'b0; bus.div_busy_i = 1'b0;
        bus.div_quotient_i = '0; bus.div_remainder_i = '0;
        bus.mul_hi_i = '0; bus.mul_lo_i = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_hi", bus.hi_o, 32'h0);
        chk("rst_lo", bus.lo_o, 32'h0);
        chk("rst_stall", {31'b0, bus.mdu_stall_o}, 32'h0);
        chk("rst_start", {31'b0, bus.div_start_o}, 32'h0);
        chk("rst_data", bus.mdu_data_o, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // single-cycle op table
        for (int i = 0; i < 12; i++) begin
            step(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].fl);
            chk($sformatf("vec%0d_data", i), o_data, vecs[i].data);
            chk($sformatf("vec%0d_stall", i), {31'b0, o_stall}, 32'h0);
            chk($sformatf("vec%0d_hi", i), bus.hi_o, vecs[i].hi);
            chk($sformatf("vec%0d_lo", i), bus.lo_o, vecs[i].lo);
        end

        // divider busy in IDLE: DIVU must wait and stall without launching
        lat = 3; ext_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(4'd2, 32'd20, 32'd3, 1'b0);
            chk("extbusy_stall", {31'b0, o_stall}, 32'h1);
            chk("extbusy_start", {31'b0, o_start}, 32'h0);
        end
        ext_busy = 1'b0;
        nstart = 0; guard = 0;
        do begin
            step(4'd2, 32'd20, 32'd3, 1'b0);
            nstart += o_start; guard++;
        end while (e_stall && guard < 100);
        guard = 0;
        while (m_inflight && guard < 100) begin
            step(4'd0, 32'd0, 32'd0, 1'b0);
            guard++;
        end
        chk("extbusy_starts", nstart, 32'd1);
        chk("extbusy_hi", bus.hi_o, 32'd2);
        chk("extbusy_lo", bus.lo_o, 32'd6);

`ifndef MDU_NONBLOCKING_DIV_EN
        // DIVU 100/7 with 33-cycle divider
        lat = 33; nstall = 0; nstart = 0; guard = 0;
        do begin
            step(4'd2, 32'd100, 32'd7, 1'b0);
            nstall += o_stall; nstart += o_start; guard++;
        end while (o_stall && guard < 200);
        chk("divu_stall_cycles", nstall, 32'd34);
        chk("divu_starts", nstart, 32'd1);
        chk("divu_lo", bus.lo_o, 32'd14);
        chk("divu_hi", bus.hi_o, 32'd2);

        // DIV -7/2 followed by MFLO
        lat = 5; guard = 0;
        do begin
            step(4'd1, 32'hFFFF_FFF9, 32'd2, 1'b0);
            guard++;
        end while (o_stall && guard < 100);
        step(4'd7, 32'd0, 32'd0, 1'b0);
        chk("div_mflo", o_data, 32'hFFFF_FFFD);
        chk("div_hi", bus.hi_o, 32'hFFFF_FFFF);

        // flush 5 cycles after launch, divider result discarded
        lat = 10; hi_keep = bus.hi_o; lo_keep = bus.lo_o;
        step(4'd1, 32'd50, 32'd5, 1'b0);
        chk("flush_launch", {31'b0, o_start}, 32'h1);
        for (int i = 0; i < 4; i++) step(4'd1, 32'd50, 32'd5, 1'b0);
        step(4'd1, 32'd50, 32'd5, 1'b1);
        chk("flush_stall_drop", {31'b0, o_stall}, 32'h0);
        nstall = 0; guard = 0;
        do begin
            step(4'd8, 32'h55, 32'd0, 1'b0);
            nstall += o_stall; guard++;
        end while (o_stall && guard < 100);
        chk("drain_mthi_stalls", nstall, 32'd5);
        chk("drain_hi_kept", o_hi, hi_keep);
        chk("drain_lo_kept", bus.lo_o, lo_keep);
        chk("drain_mthi_hi", bus.hi_o, 32'h55);
`else
        // non-blocking DIVU 9/4, ALU op, then MTLO waits for the writeback
        lat = 6;
        step(4'd2, 32'd9, 32'd4, 1'b0);
        chk("nb_divu_stall", {31'b0, o_stall}, 32'h0);
        chk("nb_divu_start", {31'b0, o_start}, 32'h1);
        step(4'd0, 32'd0, 32'd0, 1'b0);
        nstall = 0; guard = 0;
        do begin
            step(4'd9, 32'hAA, 32'd0, 1'b0);
            nstall += o_stall; guard++;
        end while (o_stall && guard < 100);
        chk("nb_mtlo_stalls", nstall, 32'd5);
        chk("nb_hi", bus.hi_o, 32'd1);
        chk("nb_lo", bus.lo_o, 32'hAA);
`endif

        // reset in the middle of a divide; the late ready must be ignored
        lat = 8;
        step(4'd2, 32'd100, 32'd7, 1'b0);
        for (int i = 0; i < 2; i++) step(e_stall ? 4'd2 : 4'd0, 32'd100, 32'd7, 1'b0);
        bus.mdu_op_i = 4'd0;
        rst = 1'b1;
        #2;
        chk("midrst_hi", bus.hi_o, 32'h0);
        chk("midrst_lo", bus.lo_o, 32'h0);
        chk("midrst_stall", {31'b0, bus.mdu_stall_o}, 32'h0);
        model_reset();
        step(4'd0, 32'd0, 32'd0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) step(4'd0, 32'd0, 32'd0, 1'b0);
        chk("late_ready_hi", bus.hi_o, 32'h0);
        chk("late_ready_lo", bus.lo_o, 32'h0);

        // random ops; stalled instructions are held in EX
        hold = 1'b0; r_op = '0; r_a = '0; r_b = '0;
        for (int i = 0; i < 1500; i++) begin
            if (!hold) begin
                r_op = 4'($urandom_range(0, 15));
                r_a  = $urandom;
                r_b  = ($urandom_range(0, 15) == 0) ? 32'd0 : $urandom;
            end
            r_fl     = ($urandom_range(0, 7) == 0);
            ext_busy = (dv_cnt == 0) && ($urandom_range(0, 15) == 0);
            lat      = $urandom_range(1, 8);
            step(r_op, r_a, r_b, r_fl);
            hold = e_stall;
        end
        ext_busy = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/mdu_seq_ctrl.md
Name: mdu_seq_ctrl

Overview:
- Sequencing controller for the multiply/divide unit.
- Owns the architectural HI/LO registers and decodes MDU ops issued from the EX stage.
- Launches and tracks the iterative divider, commits multiplier/divider results, and generates the pipeline stall.
- Sits between the EX-stage decode and the Divider/Multiplier instances; replaces ad-hoc stall logic with an explicit FSM plus flush handling.

Parameters:
- WIDTH, 32, operand/HI/LO width

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- mdu_op_i  in  4  op code (constants below); NOP when no MDU instruction
- mdu_a_i  in  WIDTH  rs operand
- mdu_b_i  in  WIDTH  rt operand
- flush_i  in  1  kills the EX-stage instruction this cycle
- mdu_data_o  out  WIDTH  MFHI/MFLO/MUL result
- mdu_stall_o  out  1  hold EX stage
- div_start_o  out  1  one-cycle divider launch
- div_signed_o  out  1  signed divide
- div_ready_i  in  1  divider done pulse
- div_busy_i  in  1  divider iterating
- div_quotient_i  in  WIDTH  quotient
- div_remainder_i  in  WIDTH  remainder
- mul_signed_o  out  1  signed multiply
- mul_hi_i  in  WIDTH  product high word
- mul_lo_i  in  WIDTH  product low word
- hi_o  out  WIDTH  current HI (debug/forwarding)
- lo_o  out  WIDTH  current LO (debug/forwarding)

Behaviour:
- Reset (async): HI=LO=0, state IDLE, done_r=0. All outputs 0.
- Op codes: NOP=0, DIV=1, DIVU=2, MUL=3, MULT=4, MULTU=5, MFHI=6, MFLO=7, MTHI=8, MTLO=9; 10-15 are treated as NOP.
- Signedness: mul_signed_o=1 for MUL/MULT. div_signed_o=1 for DIV.
- Single-cycle ops, cycle T, state IDLE, !flush_i:
  - MULT/MULTU/MUL: HI<=mul_hi_i, LO<=mul_lo_i at the end of T.
  - MUL: mdu_data_o=mul_lo_i combinationally in T.
  - MTHI: HI<=mdu_a_i. MTLO: LO<=mdu_a_i.
  - MFHI/MFLO: mdu_data_o=HI/LO, combinational.
  - None of these stall.
- FSM states: IDLE, BUSY, DRAIN.
- IDLE + DIV/DIVU + !div_busy_i + !flush_i + !done_r:
  - div_start_o=1 for one cycle; next state BUSY.
  - If div_busy_i is high, wait in IDLE and stall.
- BUSY + div_ready_i: HI<=div_remainder_i, LO<=div_quotient_i, done_r<=1, next state IDLE.
- DRAIN + div_ready_i: no HI/LO write; next state IDLE.
- Blocking mode (default):
  - mdu_stall_o=1 while the EX op is DIV/DIVU and done_r=0.
  - Done cycle is T+N; stall drops at T+N+1, when done_r=1 and the DIV retires. done_r clears at that edge.
  - flush_i in BUSY: next state DRAIN, stall drops.
  - flush_i on the launch cycle: div_start_o suppressed.
- Any non-NOP op while state≠IDLE stalls until IDLE.
- flush_i suppresses all HI/LO writes and div_start_o for that cycle, and clears done_r.
- Divide by zero: divider output is committed unchanged; no trap.
- Simultaneous BUSY completion and new op: the op is stalled that cycle, so there is no write conflict.

Optional Feature:
- Macro: MDU_NONBLOCKING_DIV_EN.
- Defined:
  - DIV/DIVU retires on its launch cycle (no stall).
  - Only later MDU ops stall while BUSY.
  - flush_i does not cancel an in-flight divide (already committed); DRAIN is unused.
  - A flush in BUSY still completes the HI/LO writeback.
- Undefined: blocking behaviour above.

Decomposition:
- MDU op-code constants and FSM state encodings go in the shared CPUConstants include; reuse the existing MDU_OP_* names.
- One sub-module, mdu_hilo_regs: HI/LO storage with independent write enables and async reset.
- FSM and stall/launch logic stay in mdu_seq_ctrl.

Test Plan:
- MULT a=0xFFFFFFFE, b=3 (mul model 0xFFFFFFFF/0xFFFFFFFA), then MFHI, MFLO -> 0xFFFFFFFF, 0xFFFFFFFA; no stall cycles.
- DIVU 100/7, divider latency 33 -> one div_start_o pulse, stall for 34 cycles, then LO=14, HI=2.
- DIV -7/2 then immediate MFLO -> MFLO stalls until commit and returns 0xFFFFFFFD; HI=0xFFFFFFFF.
- Blocking DIV, flush_i asserted 5 cycles after launch -> state DRAIN, stall drops, HI/LO unchanged after div_ready_i, next MTHI 0x55 stalls until IDLE then HI=0x55.
- MDU_NONBLOCKING_DIV_EN: DIVU 9/4 followed by an ALU op and MTLO 0xAA -> DIVU no stall; MTLO stalls until done. Final HI=1, LO=0xAA.
- Assert rst_i mid-divide -> HI=LO=0, state IDLE, mdu_stall_o=0 immediately; late div_ready_i ignored.
